// File: rtl/ahb_apb_bridge_pkg.sv
// rtl/ahb_apb_bridge_pkg.sv - shared AHB/APB decode types and bridge state encoding
package ahb_apb_bridge_pkg;

    localparam int HADDR_SIZE = 32;
    localparam int HDATA_SIZE = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } trans_type_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HWORD = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011,
        HSIZE_4WORD = 3'b100,
        HSIZE_8WORD = 3'b101,
        HSIZE_512   = 3'b110,
        HSIZE_1024  = 3'b111
    } size_t;

    typedef enum logic {
        RW_READ  = 1'b0,
        RW_WRITE = 1'b1
    } rw_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } burst_type_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } bridge_state_t;

endpackage

// File: rtl/apb_strb_gen.sv
// rtl/apb_strb_gen.sv - HSIZE/address to APB write byte strobe decoder
module apb_strb_gen
    import ahb_apb_bridge_pkg::*;
(
    input  size_t      size,
    input  logic [1:0] addr,
    input  logic       write,
    output logic [3:0] strb
);

    // Reads never assert strobes; oversize transfers are rejected upstream.
    always_comb begin
        strb = 4'h0;
        if (write) begin
            case (size)
                HSIZE_BYTE:  strb = 4'b0001 << addr;
                HSIZE_HWORD: strb = 4'b0011 << {addr[1], 1'b0};
                HSIZE_WORD:  strb = 4'b1111;
                default:     strb = 4'h0;
            endcase
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// rtl/ahb2apb_bridge.sv - AHB-Lite slave to APB4 master bridge, single outstanding transfer
module ahb2apb_bridge
    import ahb_apb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [HADDR_SIZE-1:0] PADDR,
    output logic                  PWRITE,
    output logic [HDATA_SIZE-1:0] PWDATA,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    input  logic [HDATA_SIZE-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    bridge_state_t    state;
    bridge_state_t    next_state;
    logic [CNT_W-1:0] acc_cnt;
    logic             accept;
    logic             take;
    logic             size_err;
    logic             timeout_hit;
    logic [3:0]       strb_calc;
    logic             psel_d;
    logic             penable_d;
    logic             hreadyout_d;
    logic             hresp_d;
    logic             unused_inputs;

    assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT[3:2], HTRANS[0]};

    // New beats are only sampled while HREADYOUT is high.
    assign accept      = HSEL && HREADY && HTRANS[1];
    assign take        = accept && ((state == ST_IDLE) || (state == ST_ERR2));
    assign size_err    = HSIZE > 3'd2;
    assign timeout_hit = (TIMEOUT != 0) && (acc_cnt == CNT_W'(TIMEOUT - 1));

    apb_strb_gen u_strb_gen (
        .size  (size_t'(HSIZE)),
        .addr  (HADDR[1:0]),
        .write (HWRITE),
        .strb  (strb_calc)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_ERR2: begin
                next_state = ST_IDLE;
                if (take) begin
                    if (size_err) begin
                        next_state = ST_ERR1;
                    end else if (HWRITE == RW_WRITE) begin
                        next_state = ST_WDATA;
                    end else begin
                        next_state = ST_SETUP;
                    end
                end
            end
            ST_WDATA:  next_state = ST_SETUP;
            ST_SETUP:  next_state = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    next_state = PSLVERR ? ST_ERR1 : ST_IDLE;
                end else if (timeout_hit) begin
                    next_state = ST_ERR1;
                end
            end
            ST_ERR1:   next_state = ST_ERR2;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered so they line up with the state.
    always_comb begin
        psel_d      = (next_state == ST_SETUP) || (next_state == ST_ACCESS);
        penable_d   = (next_state == ST_ACCESS);
        hreadyout_d = (next_state == ST_IDLE) || (next_state == ST_ERR2);
        hresp_d     = (next_state == ST_ERR1) || (next_state == ST_ERR2);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            HREADYOUT <= hreadyout_d;
            HRESP     <= hresp_d;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSTRB   <= 4'h0;
            PPROT   <= 3'b000;
            HRDATA  <= '0;
            acc_cnt <= '0;
        end else begin
            if (take) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
                PSTRB  <= strb_calc;
                PPROT  <= {!HPROT[0], 1'b0, HPROT[1]};
            end
            if (state == ST_WDATA) begin
                PWDATA <= HWDATA;
            end
            if ((state == ST_ACCESS) && PREADY && !PSLVERR && !PWRITE) begin
                HRDATA <= PRDATA;
            end
            acc_cnt <= (state == ST_ACCESS) ? acc_cnt + 1'b1 : '0;
        end
    end

endmodule
